// File: rtl/rsa_pkg.sv
// Shared types and sizing helpers for the RSA datapath blocks.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mont_state_t;

  localparam int MONT_WIDTH = 4;
  localparam int CNT_W      = $clog2(MONT_WIDTH);

  // Bit counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/montgomery_step.sv
// One radix-2 Montgomery iteration: add the selected multiplicand, make the
// sum even by adding M when its LSB is set, then halve it.
module montgomery_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH+1:0] acc,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH+1:0] acc_nxt
);

  localparam int ACC_W = WIDTH + 2;

  logic [ACC_W-1:0] t;
  logic [ACC_W:0]   u;

  // The extra bit on u keeps the halving exact even for out-of-range operands.
  always_comb begin
    t       = acc + (a_bit ? ACC_W'(B) : '0);
    u       = {1'b0, t} + (t[0] ? (ACC_W + 1)'(M) : '0);
    acc_nxt = ACC_W'(u >> 1);
  end

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial radix-2 Montgomery multiplier: R_o = A*B*2^-WIDTH mod M.
// state | meaning
// IDLE  | waiting for start; eoc drops on the first enabled edge here
// CALC  | one multiplier bit consumed per enabled edge, LSB first
// DONE  | final conditional subtraction, R_o loaded, eoc raised
module montgomery_mult
  import rsa_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] R_o,
  output logic             eoc,
  output logic             busy
);

  localparam int ACC_W    = WIDTH + 2;
  localparam int CNT_BITS = cnt_width(WIDTH);

  mont_state_t         state;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    m_q;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic                a_bit;

  assign a_bit = a_q[cnt];

  montgomery_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .a_bit   (a_bit),
    .B       (b_q),
    .M       (m_q),
    .acc_nxt (acc_nxt)
  );

  // Sequencer, datapath registers and registered outputs; en=0 freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      R_o   <= '0;
      eoc   <= 1'b0;
      busy  <= 1'b0;
    end else if (en) begin
      eoc <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            m_q   <= M;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_BITS'(1);
          if (cnt == CNT_BITS'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // acc < 2M for legal operands, so one subtraction fully reduces it.
          R_o   <= WIDTH'((acc >= ACC_W'(m_q)) ? acc - ACC_W'(m_q) : acc);
          eoc   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult.sv
// Scoreboard bench for montgomery_mult with a modular-arithmetic reference.
module tb_montgomery_mult;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] M;
  logic [W-1:0] R_o;
  logic         eoc;
  logic         busy;

  montgomery_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .A     (A),
    .B     (B),
    .M     (M),
    .R_o   (R_o),
    .eoc   (eoc),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_cnt = 0;
  int   next_ok  = 0;
  int   last_r   = 0;

  function automatic void chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // x such that x * 2^W == a*b (mod m), found by search.
  function automatic int mont_ref(input int a, input int b, input int m);
    int prod;
    int r2;
    prod = (a * b) % m;
    r2   = (1 << W) % m;
    for (int x = 0; x < m; x++) begin
      if ((x * r2) % m == prod) return x;
    end
    return -1;
  endfunction

  // Acceptance model on the stimulus side plus output monitor after each enabled edge.
  always @(posedge clk) begin
    bit   en_s;
    bit   eoc_exp;
    bit   busy_exp;
    exp_t e;
    en_s = en;
    if (rst) begin
      exp_q.delete();
      next_ok = 0;
      last_r  = 0;
    end else if (en_s) begin
      edge_cnt++;
      if (start && edge_cnt >= next_ok) begin
        exp_q.push_back('{mont_ref(int'(A), int'(B), int'(M)), edge_cnt});
        next_ok = edge_cnt + W + 2;
      end
      #1;
      eoc_exp  = (exp_q.size() > 0) && (edge_cnt == exp_q[0].st + W + 1);
      busy_exp = (exp_q.size() > 0) && (edge_cnt <  exp_q[0].st + W + 1);
      chk("eoc", int'(eoc), int'(eoc_exp));
      chk("busy", int'(busy), int'(busy_exp));
      if (eoc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_eoc", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", edge_cnt - e.st, W + 1);
          chk("R_o", int'(R_o), e.r);
          last_r = e.r;
        end
      end else begin
        if (eoc_exp) void'(exp_q.pop_front());
        chk("R_o_hold", int'(R_o), last_r);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input int a, input int b, input int m);
    A = W'(a); B = W'(b); M = W'(m); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rand_ops(output int a, output int b, output int m);
    m = $urandom_range(1, 7) * 2 + 1;
    a = $urandom_range(0, m - 1);
    b = $urandom_range(0, m - 1);
  endtask

  initial begin
    int a, b, m;
    rst = 1'b1; en = 1'b0; start = 1'b0; A = '0; B = '0; M = '0;
    cyc(3);
    chk("rst_R_o", int'(R_o), 0);
    chk("rst_eoc", int'(eoc), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    en  = 1'b1;
    cyc(2);

    // Directed vectors, including the final-subtraction path.
    op(7, 5, 13);   cyc(7);
    op(14, 14, 15); cyc(7);
    op(12, 12, 13); cyc(7);
    // Zero result, then back-to-back at the earliest accepted edge.
    op(0, 9, 13);   cyc(5);
    op(7, 5, 13);   cyc(8);

    // Stall mid-CALC and again while in DONE.
    op(7, 5, 13);
    cyc(1); en = 1'b0; cyc(3); en = 1'b1;
    cyc(3); en = 1'b0; cyc(3); en = 1'b1;
    cyc(8);

    // start held high with operands changing every cycle.
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rand_ops(a, b, m);
      A = W'(a); B = W'(b); M = W'(m);
      @(negedge clk);
    end
    start = 1'b0;
    cyc(8);

    // Asynchronous reset mid-CALC, then a fresh operation.
    op(14, 14, 15);
    cyc(2);
    rst = 1'b1;
    #1;
    chk("async_rst_R_o", int'(R_o), 0);
    chk("async_rst_eoc", int'(eoc), 0);
    chk("async_rst_busy", int'(busy), 0);
    cyc(2);
    rst = 1'b0;
    cyc(8);
    op(12, 12, 13); cyc(8);

    // Random operands with a randomly gated enable.
    for (int i = 0; i < 40; i++) begin
      rand_ops(a, b, m);
      A = W'(a); B = W'(b); M = W'(m); start = 1'b1;
      en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 10; j++) begin
        en = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
    end

    en = 1'b1; start = 1'b0;
    cyc(12);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
